// File: rtl/abc_pipe_pkg.sv
// Shared definitions for the ABC L0 pipeline entry stage: entry modes and default sizes.
package abc_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_PHYS = 2'b00,
    MODE_TEST = 2'b01,
    MODE_BCID = 2'b10,
    MODE_WALK = 2'b11
  } mode_e;

  localparam int unsigned DEF_WIDTH      = 256;
  localparam int unsigned DEF_BCID_W     = 8;
  localparam int unsigned DEF_DIAG_WIN_W = 4;
  localparam int unsigned OCC_W          = 16;

endpackage

// File: rtl/abc_diag_accum.sv
// Windowed OR-accumulator of strip hits for diagnostic readback.
// OCCUPANCY_EN adds a saturating count of hit BCs per window.
module abc_diag_accum
  import abc_pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DIAG_WIN_W = DEF_DIAG_WIN_W
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [WIDTH-1:0]      hit_i,
  input  logic [WIDTH-1:0]      mask_i,
  input  logic [DIAG_WIN_W-1:0] diag_win_i,
  output logic [WIDTH-1:0]      diag_o,
  output logic                  diag_valid_o,
  output logic [OCC_W-1:0]      occ_o
);

  logic [DIAG_WIN_W-1:0] cnt_q;
  logic [DIAG_WIN_W-1:0] len;
  logic                  start_q;
  logic                  last;
  logic [WIDTH-1:0]      acc_q;
  logic [WIDTH-1:0]      diag_q;
  logic                  diag_valid_q;

  // start_q marks the first BC of a window, where the length is taken from diag_win_i
  always_comb begin
    len  = start_q ? diag_win_i : cnt_q;
    last = (len == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q        <= '0;
      start_q      <= 1'b1;
      acc_q        <= '0;
      diag_q       <= '0;
      diag_valid_q <= 1'b0;
    end else if (last) begin
      diag_q       <= acc_q | hit_i;
      diag_valid_q <= 1'b1;
      acc_q        <= '0;
      start_q      <= 1'b1;
      cnt_q        <= '0;
    end else begin
      acc_q        <= acc_q | hit_i;
      diag_valid_q <= 1'b0;
      start_q      <= 1'b0;
      cnt_q        <= len - DIAG_WIN_W'(1);
    end
  end

  assign diag_o       = diag_q;
  assign diag_valid_o = diag_valid_q;

`ifdef OCCUPANCY_EN
  logic [OCC_W-1:0] occ_cnt_q;
  logic [OCC_W-1:0] occ_cnt_d;
  logic [OCC_W-1:0] occ_q;

  always_comb begin
    occ_cnt_d = occ_cnt_q;
    if ((|(hit_i & ~mask_i)) && (occ_cnt_q != '1)) occ_cnt_d = occ_cnt_q + OCC_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      occ_cnt_q <= '0;
      occ_q     <= '0;
    end else if (last) begin
      occ_q     <= occ_cnt_d;
      occ_cnt_q <= '0;
    end else begin
      occ_cnt_q <= occ_cnt_d;
    end
  end

  assign occ_o = occ_q;
`else
  logic unused_mask;
  assign unused_mask = ^mask_i;
  assign occ_o       = '0;
`endif

endmodule

// File: rtl/abc_pipeline_entry_v2.sv
// ABC L0 pipeline input stage: strip registration, edge detect, entry-mode select, diagnostics.
// OCCUPANCY_EN enables the per-window occupancy counter in abc_diag_accum.
module abc_pipeline_entry_v2
  import abc_pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned BCID_W     = DEF_BCID_W,
  parameter int unsigned DIAG_WIN_W = DEF_DIAG_WIN_W
) (
  input  logic                  BCclk,
  input  logic                  hrdrstb,
  input  logic [WIDTH-1:0]      stripData,
  input  logic [WIDTH-1:0]      maskBits,
  input  logic [BCID_W-1:0]     BCID,
  input  logic [1:0]            mode,
  input  logic                  edgeDetect,
  input  logic [DIAG_WIN_W-1:0] diagWin,
  output logic [WIDTH-1:0]      pipeLine,
  output logic                  pipeValid,
  output logic [WIDTH-1:0]      diagnostic,
  output logic                  diagValid,
  output logic [15:0]           occupancy
);

  localparam int unsigned PTR_W = $clog2(WIDTH);
  localparam int unsigned REPS  = WIDTH / BCID_W;

  logic [WIDTH-1:0] sin_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] bcid_word;
  logic [WIDTH-1:0] pipe_q;
  logic [WIDTH-1:0] pipe_d;
  logic             pipe_valid_q;
  logic             pipe_valid_d;
  logic [1:0]       fill_q;
  mode_e            mode_q;
  mode_e            mode_in;
  logic [PTR_W-1:0] walk_q;
  logic [PTR_W-1:0] walk_d;
  logic [PTR_W-1:0] walk_cur;

  assign mode_in = mode_e'(mode);

  // walk_cur restarts at 0 whenever the previous BC was not in walking-one mode
  always_comb begin
    hit       = edgeDetect ? (sin_q & ~prev_q) : sin_q;
    bcid_word = '0;
    for (int unsigned i = 0; i < REPS; i++) bcid_word[i*BCID_W +: BCID_W] = BCID;
    walk_cur = (mode_q == MODE_WALK) ? walk_q : '0;
    walk_d   = (walk_cur == PTR_W'(WIDTH - 1)) ? '0 : walk_cur + PTR_W'(1);
    pipe_d   = '0;
    unique case (mode_in)
      MODE_PHYS: pipe_d = hit & ~maskBits;
      MODE_TEST: pipe_d = maskBits;
      MODE_BCID: pipe_d = bcid_word;
      MODE_WALK: pipe_d[walk_cur] = 1'b1;
    endcase
    pipe_valid_d = (fill_q == 2'd2) && (mode_in == mode_q);
  end

  always_ff @(posedge BCclk) begin
    if (!hrdrstb) begin
      sin_q        <= '0;
      prev_q       <= '0;
      pipe_q       <= '0;
      pipe_valid_q <= 1'b0;
      fill_q       <= '0;
      mode_q       <= MODE_PHYS;
      walk_q       <= '0;
    end else begin
      sin_q        <= stripData;
      prev_q       <= sin_q;
      pipe_q       <= pipe_d;
      pipe_valid_q <= pipe_valid_d;
      mode_q       <= mode_in;
      walk_q       <= walk_d;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
    end
  end

  assign pipeLine  = pipe_q;
  assign pipeValid = pipe_valid_q;

  abc_diag_accum #(
    .WIDTH      (WIDTH),
    .DIAG_WIN_W (DIAG_WIN_W)
  ) u_diag (
    .clk_i        (BCclk),
    .rst_n_i      (hrdrstb),
    .hit_i        (hit),
    .mask_i       (maskBits),
    .diag_win_i   (diagWin),
    .diag_o       (diagnostic),
    .diag_valid_o (diagValid),
    .occ_o        (occupancy)
  );

endmodule

// File: tb/tb_abc_pipeline_entry_v2.sv
// Self-checking bench for abc_pipeline_entry_v2 (WIDTH=264): per-edge expectation queue plus scenario checks.
module tb_abc_pipeline_entry_v2;

  localparam int W  = 264;
  localparam int BW = 8;
  localparam int DW = 4;
`ifdef OCCUPANCY_EN
  localparam logic [15:0] OCC_ONE = 16'd1;
`else
  localparam logic [15:0] OCC_ONE = 16'd0;
`endif

  logic          BCclk = 1'b0;
  logic          hrdrstb;
  logic [W-1:0]  stripData, maskBits;
  logic [BW-1:0] BCID;
  logic [1:0]    mode;
  logic          edgeDetect;
  logic [DW-1:0] diagWin;
  logic [W-1:0]  pipeLine, diagnostic;
  logic          pipeValid, diagValid;
  logic [15:0]   occupancy;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [W-1:0] pipe;
    logic         valid;
    logic [W-1:0] diag;
    logic         dvalid;
    logic [15:0]  occ;
  } exp_t;
  exp_t exp_q[$];

  // reference state, advanced once per BC edge
  logic [W-1:0] m_sIn, m_prev, m_pipe, m_diag, m_acc;
  logic         m_valid, m_dvalid;
  logic [15:0]  m_occ;
  logic [1:0]   m_mode;
  int           m_fill, m_walk_run, m_hitbc, m_win_pos, m_win_len;

  abc_pipeline_entry_v2 #(.WIDTH(W), .BCID_W(BW), .DIAG_WIN_W(DW)) dut (
    .BCclk      (BCclk),
    .hrdrstb    (hrdrstb),
    .stripData  (stripData),
    .maskBits   (maskBits),
    .BCID       (BCID),
    .mode       (mode),
    .edgeDetect (edgeDetect),
    .diagWin    (diagWin),
    .pipeLine   (pipeLine),
    .pipeValid  (pipeValid),
    .diagnostic (diagnostic),
    .diagValid  (diagValid),
    .occupancy  (occupancy)
  );

  initial forever #5 BCclk = ~BCclk;

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i += 32) r = (r << 32) | W'($urandom);
    return r;
  endfunction

  task automatic model_step();
    exp_t e;
    logic [W-1:0] h;
    h = edgeDetect ? (m_sIn & ~m_prev) : m_sIn;
    if (!hrdrstb) begin
      m_sIn = '0; m_prev = '0; m_pipe = '0; m_diag = '0; m_acc = '0;
      m_valid = 0; m_dvalid = 0; m_occ = '0; m_mode = 2'b00;
      m_fill = 0; m_walk_run = 0; m_hitbc = 0; m_win_pos = 0; m_win_len = 1;
    end else begin
      m_valid = (m_fill >= 2) && (mode == m_mode);
      if (m_fill < 2) m_fill++;
      case (mode)
        2'b00: m_pipe = h & ~maskBits;
        2'b01: m_pipe = maskBits;
        2'b10: begin
          m_pipe = '0;
          for (int i = 0; i < W / BW; i++) m_pipe[i*BW +: BW] = BCID;
        end
        default: begin
          if (m_mode != 2'b11) m_walk_run = 0;
          m_pipe = '0;
          m_pipe[m_walk_run % W] = 1'b1;
          m_walk_run++;
        end
      endcase
      if (m_win_pos == 0) m_win_len = int'(diagWin) + 1;
      m_acc = m_acc | h;
      if (|(h & ~maskBits)) m_hitbc++;
      m_win_pos++;
      m_dvalid = 0;
      if (m_win_pos == m_win_len) begin
        m_diag = m_acc;
`ifdef OCCUPANCY_EN
        m_occ = (m_hitbc > 65535) ? 16'hFFFF : 16'(m_hitbc);
`endif
        m_dvalid = 1;
        m_acc = '0; m_hitbc = 0; m_win_pos = 0;
      end
      m_prev = m_sIn; m_sIn = stripData; m_mode = mode;
    end
    e.pipe = m_pipe; e.valid = m_valid; e.diag = m_diag; e.dvalid = m_dvalid; e.occ = m_occ;
    exp_q.push_back(e);
  endtask

  // pushes the expectation for the coming edge, then advances to just after it
  task automatic tick();
    model_step();
    @(posedge BCclk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    hrdrstb = 1'b0;
    repeat (3) begin
      stripData = rand_word(); maskBits = rand_word(); BCID = BW'($urandom);
      mode = 2'($urandom); edgeDetect = 1'($urandom); diagWin = DW'($urandom);
      tick();
      e = exp_q.pop_front();
      n_total++;
      if (pipeLine !== '0 || pipeValid !== 1'b0 || diagnostic !== '0 || diagValid !== 1'b0 || occupancy !== '0)
        $display("FAIL reset_outputs: got pipe=%h v=%b diag=%h dv=%b occ=%h want all 0",
                 pipeLine, pipeValid, diagnostic, diagValid, occupancy);
      else n_pass++;
    end
    stripData = '0; maskBits = '0; mode = 2'b00; edgeDetect = 1'b0; diagWin = '0;
    hrdrstb = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      e = exp_q.pop_front();
      n_total++;
      if (pipeValid !== (k == 3)) $display("FAIL fill_valid edge%0d: got %b want %b", k, pipeValid, (k == 3));
      else n_pass++;
    end
  endtask

  task automatic test_physics();
    exp_t e;
    logic [W-1:0] p;
    logic [W-1:0] sq[$];
    p = rand_word();
    mode = 2'b00; edgeDetect = 1'b0; maskBits = W'(8'hFF);
    for (int k = 0; k < 8; k++) begin
      stripData = k[0] ? ~p : p;
      sq.push_back(stripData & ~maskBits);
      tick();
      e = exp_q.pop_front();
      if (sq.size() == 2) begin
        n_total++;
        if (pipeLine !== sq[0]) $display("FAIL phys_latency bc%0d: got %h want %h", k, pipeLine, sq[0]);
        else n_pass++;
        void'(sq.pop_front());
      end
      n_total++;
      if (pipeLine[7:0] !== 8'h00 || pipeValid !== e.valid)
        $display("FAIL phys_mask bc%0d: got low=%h v=%b want low=00 v=%b", k, pipeLine[7:0], pipeValid, e.valid);
      else n_pass++;
    end
  endtask

  task automatic test_edge();
    exp_t e;
    int ones = 0;
    mode = 2'b00; maskBits = '0; edgeDetect = 1'b1; stripData = '0;
    repeat (3) begin tick(); e = exp_q.pop_front(); end
    for (int k = 0; k < 6; k++) begin
      stripData = (k < 4) ? W'(1) : '0;
      tick();
      e = exp_q.pop_front();
      if (pipeLine[0]) ones++;
      n_total++;
      if (pipeLine !== e.pipe) $display("FAIL edge_pipe bc%0d: got %h want %h", k, pipeLine, e.pipe);
      else n_pass++;
    end
    n_total++;
    if (ones != 1) $display("FAIL edge_once: got %0d want 1", ones);
    else n_pass++;
    edgeDetect = 1'b0; stripData = '0;
  endtask

  task automatic test_bcid_walk();
    exp_t e;
    logic [W-1:0] want;
    mode = 2'b10; BCID = 8'h05;
    repeat (2) begin tick(); e = exp_q.pop_front(); end
    want = '0;
    for (int i = 0; i < 33; i++) want[i*8 +: 8] = 8'h05;
    n_total++;
    if (pipeLine !== want || pipeValid !== 1'b1)
      $display("FAIL bcid_word: got %h v=%b want %h v=1", pipeLine, pipeValid, want);
    else n_pass++;
    mode = 2'b11;
    for (int k = 0; k < W + 2; k++) begin
      tick();
      e = exp_q.pop_front();
      want = '0;
      want[(k < W) ? k : k - W] = 1'b1;
      n_total++;
      if (pipeLine !== want || pipeValid !== (k != 0))
        $display("FAIL walk bc%0d: got %h v=%b want %h v=%b", k, pipeLine, pipeValid, want, (k != 0));
      else n_pass++;
    end
  endtask

  task automatic test_mode_change();
    exp_t e;
    mode = 2'b00; maskBits = rand_word();
    repeat (2) begin tick(); e = exp_q.pop_front(); end
    mode = 2'b01;
    tick();
    e = exp_q.pop_front();
    n_total++;
    if (pipeValid !== 1'b0) $display("FAIL modechg_invalid: got %b want 0", pipeValid);
    else n_pass++;
    tick();
    e = exp_q.pop_front();
    n_total++;
    if (pipeValid !== 1'b1 || pipeLine !== maskBits)
      $display("FAIL modechg_mask: got %h v=%b want %h v=1", pipeLine, pipeValid, maskBits);
    else n_pass++;
  endtask

  task automatic test_diag();
    exp_t e;
    logic want_dv;
    mode = 2'b00; maskBits = '0; edgeDetect = 1'b0; stripData = '0; diagWin = 4'd3;
    hrdrstb = 1'b0;
    repeat (2) begin tick(); e = exp_q.pop_front(); end
    hrdrstb = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      stripData = (k == 1) ? W'(1) << 7 : '0;
      if (k == 6) diagWin = 4'd1;
      if (k == 10) diagWin = 4'd3;
      hrdrstb = (k != 16);
      tick();
      e = exp_q.pop_front();
      want_dv = (k == 4 || k == 8 || k == 10 || k == 14 || k == 20);
      n_total++;
      if (diagValid !== want_dv || diagValid !== e.dvalid)
        $display("FAIL diag_pulse bc%0d: got %b want %b", k, diagValid, want_dv);
      else n_pass++;
      n_total++;
      if (diagnostic !== e.diag || occupancy !== e.occ)
        $display("FAIL diag_map bc%0d: got %h occ=%h want %h occ=%h", k, diagnostic, occupancy, e.diag, e.occ);
      else n_pass++;
      if (k == 4) begin
        n_total++;
        if (diagnostic !== (W'(1) << 7) || occupancy !== OCC_ONE)
          $display("FAIL diag_first: got %h occ=%h want bit7 occ=%h", diagnostic, occupancy, OCC_ONE);
        else n_pass++;
      end
    end
  endtask

  initial begin
    hrdrstb = 1'b0; stripData = '0; maskBits = '0; BCID = '0;
    mode = 2'b00; edgeDetect = 1'b0; diagWin = '0;
    test_reset();
    test_physics();
    test_edge();
    test_bcid_walk();
    test_mode_change();
    test_diag();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
